// File: rtl/cache_fill_ctrl.sv
// Line-fill controller shared by the I-cache and D-cache: owns the memory read port,
// streams a 16-byte line in as eight 16-bit words, then writes the tag. D-cache wins ties.
module cache_fill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic [15:0]       mem_data_in,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [15:0]       fill_data,
    output logic [7:0]        fill_tag,
    output logic              icache_write_data,
    output logic              icache_write_tag,
    output logic              dcache_write_data,
    output logic              dcache_write_tag,
    output logic              icache_stall,
    output logic              dcache_stall,
    output logic              fill_done
);

    // state     | meaning
    // IDLE      | waiting for a miss; stalls mirror the miss inputs
    // FILL      | issuing line reads and writing returned words into the data array
    // WRITE_TAG | writing the tag (valid) of the filled line
    // DONE      | one-cycle completion pulse, owner released
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int BASE_W = ADDR_W - OFF_W - 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE_TAG, DONE} state_t;

    state_t            state, state_nxt;
    logic              owner_d;
    logic [BASE_W-1:0] line_base;
    logic [OFF_W-1:0]  iss_cnt;
    logic [OFF_W-1:0]  rcv_cnt;
    logic              iss_done;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{icache_miss_addr[OFF_W:0], dcache_miss_addr[OFF_W:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b1;
            line_base <= '0;
            iss_cnt   <= '0;
            rcv_cnt   <= '0;
            iss_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                iss_cnt  <= '0;
                rcv_cnt  <= '0;
                iss_done <= 1'b0;
                if (dcache_miss) begin
                    owner_d   <= 1'b1;
                    line_base <= dcache_miss_addr[ADDR_W-1:OFF_W+1];
                end else if (icache_miss) begin
                    owner_d   <= 1'b0;
                    line_base <= icache_miss_addr[ADDR_W-1:OFF_W+1];
                end
            end else if (state == FILL) begin
                if (!iss_done) begin
                    iss_cnt <= iss_cnt + 1'b1;
                    if (iss_cnt == OFF_W'(LINE_WORDS - 1))
                        iss_done <= 1'b1;
                end
                if (mem_data_valid)
                    rcv_cnt <= rcv_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        mem_en            = 1'b0;
        mem_addr          = '0;
        fill_addr         = '0;
        fill_data         = '0;
        fill_tag          = '0;
        icache_write_data = 1'b0;
        icache_write_tag  = 1'b0;
        dcache_write_data = 1'b0;
        dcache_write_tag  = 1'b0;
        icache_stall      = 1'b0;
        dcache_stall      = 1'b0;
        fill_done         = 1'b0;

        case (state)
            IDLE: begin
                icache_stall = icache_miss;
                dcache_stall = dcache_miss;
                if (dcache_miss || icache_miss)
                    state_nxt = FILL;
            end
            FILL: begin
                icache_stall = owner_d ? icache_miss : 1'b1;
                dcache_stall = owner_d ? 1'b1 : dcache_miss;
                if (!iss_done) begin
                    mem_en   = 1'b1;
                    mem_addr = {line_base, iss_cnt, 1'b0};
                end
                // Tag is written last so the cache keeps missing and its victim way stays put.
                if (mem_data_valid) begin
                    icache_write_data = !owner_d;
                    dcache_write_data = owner_d;
                    fill_addr         = {line_base, rcv_cnt, 1'b0};
                    fill_data         = mem_data_in;
                    if (rcv_cnt == OFF_W'(LINE_WORDS - 1))
                        state_nxt = WRITE_TAG;
                end
            end
            WRITE_TAG: begin
                icache_stall     = owner_d ? icache_miss : 1'b1;
                dcache_stall     = owner_d ? 1'b1 : dcache_miss;
                icache_write_tag = !owner_d;
                dcache_write_tag = owner_d;
                fill_addr        = {line_base, {(OFF_W + 1){1'b0}}};
                fill_tag         = {line_base[BASE_W-1 -: 6], 1'b1, 1'b0};
                state_nxt        = DONE;
            end
            DONE: begin
                icache_stall = owner_d ? icache_miss : 1'b0;
                dcache_stall = owner_d ? 1'b0 : dcache_miss;
                fill_done    = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // State is already IDLE under reset; only the pass-through stalls need forcing low.
        if (rst) begin
            icache_stall = 1'b0;
            dcache_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: transaction-level fill model plus an in-order memory with
// variable latency and gaps; table-driven fills, directed corner cases, random traffic.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss, mem_data_valid;
    logic [15:0] icache_miss_addr, dcache_miss_addr, mem_data_in;
    logic        mem_en;
    logic [15:0] mem_addr, fill_addr, fill_data;
    logic [7:0]  fill_tag;
    logic        icache_write_data, icache_write_tag, dcache_write_data, dcache_write_tag;
    logic        icache_stall, dcache_stall, fill_done;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_addr(mem_addr), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_tag(fill_tag),
        .icache_write_data(icache_write_data), .icache_write_tag(icache_write_tag),
        .dcache_write_data(dcache_write_data), .dcache_write_tag(dcache_write_tag),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [15:0] maddr;
        logic [15:0] faddr;
        logic [15:0] fdata;
        logic [7:0]  ftag;
        logic        iwd, iwt, dwd, dwt, ist, dst, done;
    } out_t;

    typedef struct {
        int          rdy;
        logic [15:0] a;
    } mreq_t;

    typedef struct {
        bit          is_d;
        logic [15:0] addr;
        int          lat;
        logic [15:0] exp_first;
        logic [7:0]  exp_tag;
        int          exp_done;
    } fill_vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // cache-side request state
    logic        imiss_r = 1'b0, dmiss_r = 1'b0;
    logic [15:0] iaddr_r = '0, daddr_r = '0;

    // memory model
    mreq_t mq[$];
    int    lat = 1;
    int    gap_pct = 0;
    int    gap_lo = 0, gap_hi = 0;
    bit    stray = 1'b0;

    // fill model: which fill is active, where it started, how many words have arrived
    bit          m_busy = 1'b0;
    bit          m_own_d = 1'b0;
    logic [11:0] m_base = '0;
    int          m_grant = 0, m_rcv = 0, m_tag = -1;

    // observations for scenario-level checks
    bit          done_seen = 1'b0;
    int          obs_done_rel = 0, obs_writes = 0;
    logic [15:0] obs_first = '0;
    logic [7:0]  obs_tag = '0;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    function automatic out_t sample();
        return {mem_en, mem_addr, fill_addr, fill_data, fill_tag,
                icache_write_data, icache_write_tag, dcache_write_data, dcache_write_tag,
                icache_stall, dcache_stall, fill_done};
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic tick();
        out_t        exp, act;
        logic        v;
        logic [15:0] dv, bl;
        int          k;
        bit          was_busy;
        @(negedge clk);
        v  = 1'b0;
        dv = '0;
        if (mq.size() > 0 && mq[0].rdy <= cyc && !(cyc >= gap_lo && cyc < gap_hi)
            && $urandom_range(99) >= gap_pct) begin
            v  = 1'b1;
            dv = mdata(mq[0].a);
            void'(mq.pop_front());
        end else if (stray && mq.size() == 0) begin
            v  = 1'b1;
            dv = 16'($urandom);
        end
        icache_miss      = imiss_r;
        icache_miss_addr = iaddr_r;
        dcache_miss      = dmiss_r;
        dcache_miss_addr = daddr_r;
        mem_data_valid   = v;
        mem_data_in      = dv;
        #1;
        act      = sample();
        exp      = '0;
        was_busy = m_busy;
        bl       = {m_base, 4'b0};
        if (!m_busy) begin
            exp.ist = imiss_r;
            exp.dst = dmiss_r;
        end else begin
            k = cyc - m_grant;
            if (k >= 1 && k <= 8) begin
                exp.en    = 1'b1;
                exp.maddr = bl + 16'(2 * (k - 1));
            end
            if (m_own_d) exp.ist = imiss_r; else exp.dst = dmiss_r;
            if (m_tag >= 0 && cyc == m_tag) begin
                if (m_own_d) begin exp.dwt = 1'b1; exp.dst = 1'b1; end
                else         begin exp.iwt = 1'b1; exp.ist = 1'b1; end
                exp.faddr = bl;
                exp.ftag  = {bl[15:10], 2'b10};
            end else if (m_tag >= 0 && cyc == m_tag + 1) begin
                exp.done = 1'b1;
            end else begin
                if (m_own_d) exp.dst = 1'b1; else exp.ist = 1'b1;
                if (v) begin
                    if (m_own_d) exp.dwd = 1'b1; else exp.iwd = 1'b1;
                    exp.faddr = bl + 16'(2 * m_rcv);
                    exp.fdata = mdata(exp.faddr);
                    m_rcv++;
                    if (m_rcv == 8) m_tag = cyc + 1;
                end
            end
        end
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, act, exp);
        end
        if (was_busy && act.en && cyc - m_grant == 1) obs_first = act.maddr;
        if (act.iwd || act.dwd) obs_writes++;
        if (act.iwt || act.dwt) obs_tag = act.ftag;
        if (act.en) mq.push_back('{cyc + lat, act.maddr});
        if (was_busy && m_tag >= 0 && cyc == m_tag + 1) begin
            m_busy       = 1'b0;
            done_seen    = 1'b1;
            obs_done_rel = cyc - m_grant;
            if (m_own_d) dmiss_r = 1'b0; else imiss_r = 1'b0;
        end
        if (!was_busy && (imiss_r || dmiss_r)) begin
            m_busy     = 1'b1;
            m_own_d    = dmiss_r;
            m_base     = dmiss_r ? daddr_r[15:4] : iaddr_r[15:4];
            m_grant    = cyc;
            m_rcv      = 0;
            m_tag      = -1;
            obs_writes = 0;
        end
        cyc++;
    endtask

    task automatic wait_done(input int max, input string nm);
        done_seen = 1'b0;
        for (int i = 0; i < max && !done_seen; i++) tick();
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL %s_timeout got=no fill_done want=fill_done within %0d cycles", nm, max);
        end
    endtask

    fill_vec_t tv[4];
    out_t      rs;

    initial begin
        tv[0] = '{1'b0, 16'h1234, 4, 16'h1230, 8'h12, 14};
        tv[1] = '{1'b1, 16'hFFFF, 1, 16'hFFF0, 8'hFE, 11};
        tv[2] = '{1'b0, 16'h0008, 2, 16'h0000, 8'h02, 12};
        tv[3] = '{1'b1, 16'h8C5A, 3, 16'h8C50, 8'h8E, 13};

        rst = 1'b1;
        icache_miss = 1'b0; dcache_miss = 1'b0; mem_data_valid = 1'b0;
        icache_miss_addr = '0; dcache_miss_addr = '0; mem_data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(sample()), 0);
        rst = 1'b0;

        // table-driven single fills
        for (int t = 0; t < 4; t++) begin
            lat = tv[t].lat;
            if (tv[t].is_d) begin dmiss_r = 1'b1; daddr_r = tv[t].addr; end
            else            begin imiss_r = 1'b1; iaddr_r = tv[t].addr; end
            wait_done(60, "table");
            chk("table_first_addr", int'(obs_first), int'(tv[t].exp_first));
            chk("table_tag", int'(obs_tag), int'(tv[t].exp_tag));
            chk("table_done_cycle", obs_done_rel, tv[t].exp_done);
            chk("table_writes", obs_writes, 8);
            tick();
        end

        // simultaneous misses: D first, I granted right after DONE
        lat = 3;
        imiss_r = 1'b1; iaddr_r = 16'h0A06;
        dmiss_r = 1'b1; daddr_r = 16'hB0B4;
        wait_done(60, "both_d");
        chk("both_d_first_addr", int'(obs_first), 16'hB0B0);
        wait_done(60, "both_i");
        chk("both_i_first_addr", int'(obs_first), 16'h0A00);
        chk("both_i_done_cycle", obs_done_rel, 13);

        // miss withdrawn mid-fill
        lat = 2;
        dmiss_r = 1'b1; daddr_r = 16'h5E26;
        repeat (3) tick();
        dmiss_r = 1'b0;
        wait_done(60, "drop");
        chk("drop_writes", obs_writes, 8);
        chk("drop_tag", int'(obs_tag), 8'h5E);

        // memory gap: L=1, valid suppressed for 3 cycles
        lat = 1;
        imiss_r = 1'b1; iaddr_r = 16'h3C44;
        gap_lo = cyc + 5; gap_hi = cyc + 8;
        wait_done(60, "gap");
        chk("gap_done_cycle", obs_done_rel, 14);
        gap_lo = 0; gap_hi = 0;
        tick();

        // async reset after three words
        lat = 2;
        dmiss_r = 1'b1; daddr_r = 16'h4A60;
        imiss_r = 1'b1; iaddr_r = 16'h0100;
        for (int i = 0; i < 40 && !(m_busy && m_rcv == 3); i++) tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 rs = sample();
        chk("reset_midfill_outputs", int'(rs), 0);
        imiss_r = 1'b0; dmiss_r = 1'b0;
        icache_miss = 1'b0; dcache_miss = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0;
        stray = 1'b1;
        repeat (6) tick();
        stray = 1'b0;
        mq.delete();
        dmiss_r = 1'b1; daddr_r = 16'h7712;
        wait_done(60, "restart");
        chk("restart_first_addr", int'(obs_first), 16'h7710);
        chk("restart_writes", obs_writes, 8);

        // stray valid while idle
        stray = 1'b1;
        repeat (6) tick();
        stray = 1'b0;

        // random traffic
        gap_pct = 25;
        for (int n = 0; n < 3000; n++) begin
            if (mq.size() == 0 && $urandom_range(7) == 0) lat = $urandom_range(5, 1);
            if (!imiss_r && $urandom_range(9) == 0) begin imiss_r = 1'b1; iaddr_r = 16'($urandom); end
            if (!dmiss_r && $urandom_range(9) == 0) begin dmiss_r = 1'b1; daddr_r = 16'($urandom); end
            tick();
        end
        for (int i = 0; i < 300 && (m_busy || imiss_r || dmiss_r); i++) tick();
        chk("random_drained", int'(m_busy || imiss_r || dmiss_r), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
